// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - fetch stage: PC register, next-PC select, fetch-address check and IF/ID register.
// DELAY_SLOT_EN defined keeps the delay-slot instruction on redirect; undefined squashes it to a nop.
module ifu_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    input  logic [31:0] F_instr,
    output logic [31:0] F_pc,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [31:0] D_pc8,
    output logic        D_exc_adel
);

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI  = 32'h0000_3FFC;

`ifdef DELAY_SLOT_EN
    localparam bit SQUASH_EN = 1'b0;
`else
    localparam bit SQUASH_EN = 1'b1;
`endif

    logic [31:0] pc_seq;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic        redirect;
    logic        squash;
    logic        fetch_err;
    logic [31:0] fetch_word;

    assign pc_seq        = F_pc + 32'd4;
    assign branch_target = D_pc + 32'd4 + {{14{D_instr[15]}}, D_instr[15:0], 2'b00};
    assign jump_target   = {D_pc[31:28], D_instr[25:0], 2'b00};

    always_comb begin
        next_pc  = pc_seq;
        redirect = 1'b0;
        case (npc_op)
            2'b01: begin
                if (branch_taken) begin
                    next_pc  = branch_target;
                    redirect = 1'b1;
                end
            end
            2'b10: begin
                next_pc  = jump_target;
                redirect = 1'b1;
            end
            2'b11: begin
                next_pc  = jr_target;
                redirect = 1'b1;
            end
            default: begin
                next_pc  = pc_seq;
                redirect = 1'b0;
            end
        endcase
    end

    // Misaligned or outside the instruction window: fetch a nop and flag AdEL.
    assign fetch_err  = (F_pc[1:0] != 2'b00) || (F_pc < IMEM_LO) || (F_pc > IMEM_HI);
    assign fetch_word = fetch_err ? 32'h0000_0000 : F_instr;
    assign squash     = SQUASH_EN && redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            F_pc       <= RESET_PC;
            D_pc       <= RESET_PC;
            D_instr    <= 32'h0000_0000;
            D_exc_adel <= 1'b0;
        end else if (!stall) begin
            F_pc       <= next_pc;
            D_pc       <= F_pc;
            D_instr    <= squash ? 32'h0000_0000 : fetch_word;
            D_exc_adel <= squash ? 1'b0 : fetch_err;
        end
    end

    assign D_pc8 = D_pc + 32'd8;

endmodule
